// File: rtl/queen_solver.sv
// Backtracking N-queens search engine that streams each complete safe placement over valid/ready.
// Build option QUEEN_STOP_FIRST_EN: finish the search after the first accepted solution.

module queen_solver #(
  parameter int N       = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               sol_valid,
  input  logic               sol_ready,
  output logic [23:0]        sol_cols,
  output logic [COUNT_W-1:0] solution_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRY,
    S_NEXT,
    S_BACK,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST = 3'(N - 1);

`ifdef QUEEN_STOP_FIRST_EN
  localparam state_t S_AFTER_EMIT = S_DONE;
`else
  localparam state_t S_AFTER_EMIT = S_NEXT;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_col [8];
  logic [2:0]         r_row;
  logic [2:0]         r_k;
  logic [COUNT_W-1:0] r_count;

  logic [2:0] w_col_row;
  logic [2:0] w_col_k;
  logic [2:0] w_row_dist;
  logic [2:0] w_col_dist;
  logic [2:0] w_row_inc;
  logic       w_k_at_row;
  logic       w_row_last;
  logic       w_conflict;

  // Pair check: queen in row r_k against the candidate queen in row r_row.
  assign w_col_row  = r_col[r_row];
  assign w_col_k    = r_col[r_k];
  assign w_row_dist = r_row - r_k;
  assign w_col_dist = (w_col_row >= w_col_k) ? (w_col_row - w_col_k) : (w_col_k - w_col_row);
  assign w_conflict = (w_col_k == w_col_row) || (w_row_dist == w_col_dist);
  assign w_k_at_row = (r_k == r_row);
  assign w_row_last = (r_row == LAST);
  assign w_row_inc  = r_row + 3'd1;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the next-state default is assigned first so no path through this block infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_TRY;
      S_TRY: begin
        if (w_k_at_row) begin
          if (w_row_last) w_state_nxt = S_EMIT;
        end else if (w_conflict) begin
          w_state_nxt = S_NEXT;
        end
      end
      S_NEXT:  w_state_nxt = (w_col_row == LAST) ? S_BACK : S_TRY;
      S_BACK:  w_state_nxt = (r_row == 3'd0) ? S_DONE : S_NEXT;
      S_EMIT:  if (sol_ready) w_state_nxt = S_AFTER_EMIT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the column array is only eight small registers and its contents appear on sol_cols, so it is reset explicitly.
      for (int i = 0; i < 8; i++) r_col[i] <= 3'd0;
      r_row   <= 3'd0;
      r_k     <= 3'd0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int i = 0; i < 8; i++) r_col[i] <= 3'd0;
            r_row   <= 3'd0;
            r_k     <= 3'd0;
            r_count <= '0;
          end
        end
        S_TRY: begin
          if (w_k_at_row) begin
            if (!w_row_last) begin
              r_row            <= w_row_inc;
              r_col[w_row_inc] <= 3'd0;
              r_k              <= 3'd0;
            end
          end else if (!w_conflict) begin
            r_k <= r_k + 3'd1;
          end
        end
        S_NEXT: begin
          if (w_col_row != LAST) begin
            r_col[r_row] <= w_col_row + 3'd1;
            r_k          <= 3'd0;
          end
        end
        S_BACK: if (r_row != 3'd0) r_row <= r_row - 3'd1;
        S_EMIT: begin
          if (sol_ready && (r_count != '1)) r_count <= r_count + COUNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy           = (r_state == S_TRY) || (r_state == S_NEXT) ||
                          (r_state == S_BACK) || (r_state == S_EMIT);
  assign done           = (r_state == S_DONE);
  assign sol_valid      = (r_state == S_EMIT);
  assign solution_count = r_count;

  // Rows beyond the board size always read as zero.
  always_comb begin
    sol_cols = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < N) sol_cols[3*i +: 3] = r_col[i];
    end
  end

endmodule

// File: tb/tb_queen_solver.sv
// Self-checking bench for queen_solver: six instances (N = 8, 8, 4, 3, 2, 1) checked against a
// permutation-enumeration model of the N-queens solution list.

module tb_queen_solver;

  localparam int NI = 6;

  logic        clk = 1'b0;
  logic        rst_a   [NI];
  logic        start_a [NI];
  logic        ready_a [NI];
  logic        busy_a  [NI];
  logic        done_a  [NI];
  logic        valid_a [NI];
  logic [23:0] cols_a  [NI];
  logic [7:0]  cnt_a   [NI];

  int checks   = 0;
  int failures = 0;

  logic [23:0] model_all [$];
  int          model_base  [9];
  int          model_total [9];
  int          exp_count   [9];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    queen_solver #(
      .N       ((g < 2) ? 8 : 6 - g),
      .COUNT_W (8)
    ) u_dut (
      .clk            (clk),
      .rst            (rst_a[g]),
      .start          (start_a[g]),
      .busy           (busy_a[g]),
      .done           (done_a[g]),
      .sol_valid      (valid_a[g]),
      .sol_ready      (ready_a[g]),
      .sol_cols       (cols_a[g]),
      .solution_count (cnt_a[g])
    );
  end

  function automatic logic [23:0] pack8(input int c0, input int c1, input int c2, input int c3,
                                        input int c4, input int c5, input int c6, input int c7);
    return {3'(c7), 3'(c6), 3'(c5), 3'(c4), 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  // Every solution is a permutation; walking permutations in lexicographic order yields the expected emit order.
  task automatic build_model(input int n);
    int p [8];
    int i, j, t, lo, hi;
    bit more, safe;
    logic [23:0] v;
    model_base[n]  = model_all.size();
    model_total[n] = 0;
    for (int a = 0; a < 8; a++) p[a] = a;
    more = 1'b1;
    while (more) begin
      safe = 1'b1;
      for (int a = 0; a < n; a++)
        for (int b = a + 1; b < n; b++)
          if ((p[b] - p[a] == b - a) || (p[a] - p[b] == b - a)) safe = 1'b0;
      if (safe) begin
        v = '0;
        for (int a = 0; a < n; a++) v[3*a +: 3] = 3'(p[a]);
        model_all.push_back(v);
        model_total[n]++;
      end
      i = n - 2;
      while (i >= 0 && p[i] >= p[i+1]) i--;
      if (i < 0) begin
        more = 1'b0;
      end else begin
        j = n - 1;
        while (p[j] <= p[i]) j--;
        t = p[i]; p[i] = p[j]; p[j] = t;
        lo = i + 1;
        hi = n - 1;
        while (lo < hi) begin
          t = p[lo]; p[lo] = p[hi]; p[hi] = t;
          lo++;
          hi--;
        end
      end
    end
`ifdef QUEEN_STOP_FIRST_EN
    exp_count[n] = (model_total[n] > 0) ? 1 : 0;
`else
    exp_count[n] = model_total[n];
`endif
  endtask

  task automatic test_reset;
    for (int g = 0; g < NI; g++) begin
      rst_a[g] = 1'b1; start_a[g] = 1'b0; ready_a[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) rst_a[g] = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (busy_a[g] !== 1'b0 || done_a[g] !== 1'b0 || valid_a[g] !== 1'b0 ||
          cnt_a[g] !== 8'd0 || cols_a[g] !== 24'd0) begin
        failures++;
        $display("FAIL reset_state inst=%0d got busy=%b done=%b valid=%b cnt=%0d cols=%h exp all zero",
                 g, busy_a[g], done_a[g], valid_a[g], cnt_a[g], cols_a[g]);
      end
      ready_a[g] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (busy_a[g] !== 1'b0 || valid_a[g] !== 1'b0 || cnt_a[g] !== 8'd0) begin
        failures++;
        $display("FAIL idle_ready_no_effect inst=%0d got busy=%b valid=%b cnt=%0d exp 0 0 0",
                 g, busy_a[g], valid_a[g], cnt_a[g]);
      end
      ready_a[g] = 1'b0;
    end
  endtask

  // Full search on instance g; every presented solution is compared to the model in order.
  task automatic run_full(input int g, input int n, input int ready_pct, input bit stall_first,
                          output logic [23:0] first_c, output logic [23:0] second_c,
                          output logic [23:0] last_c, output int n_acc);
    int idx, cyc, hold;
    bit in_hold, just_acc;
    logic [23:0] held;
    @(negedge clk);
    start_a[g] = 1'b1;
    ready_a[g] = 1'b0;
    @(negedge clk);
    start_a[g] = 1'b0;
    checks++;
    if (busy_a[g] !== 1'b1 || done_a[g] !== 1'b0 || cnt_a[g] !== 8'd0) begin
      failures++;
      $display("FAIL start_state n=%0d got busy=%b done=%b cnt=%0d exp 1 0 0", n, busy_a[g], done_a[g], cnt_a[g]);
    end
    first_c = '0; second_c = '0; last_c = '0; held = '0;
    idx = 0; cyc = 0; hold = 0; in_hold = 1'b0; just_acc = 1'b0;
    while (1) begin
      if (just_acc) begin
        just_acc = 1'b0;
        checks++;
        if (valid_a[g] !== 1'b0 || cnt_a[g] !== 8'(idx)) begin
          failures++;
          $display("FAIL accept_step n=%0d got valid=%b cnt=%0d exp valid=0 cnt=%0d", n, valid_a[g], cnt_a[g], idx);
        end
      end
      if (done_a[g] === 1'b1) break;
      if (cyc >= 120000) begin
        checks++; failures++;
        $display("FAIL search_timeout n=%0d got no done after %0d cycles exp done", n, cyc);
        break;
      end
      checks++;
      if (busy_a[g] !== 1'b1) begin
        failures++;
        $display("FAIL busy_during_search n=%0d got %b exp 1", n, busy_a[g]);
      end
      ready_a[g] = (int'($urandom_range(99)) < ready_pct);
      if (valid_a[g] === 1'b1) begin
        if (!in_hold) begin
          checks++;
          if (idx >= exp_count[n]) begin
            failures++;
            $display("FAIL extra_solution n=%0d got cols=%h exp no more solutions", n, cols_a[g]);
          end else if (cols_a[g] !== model_all[model_base[n] + idx]) begin
            failures++;
            $display("FAIL sol_cols n=%0d idx=%0d got %h exp %h", n, idx, cols_a[g], model_all[model_base[n] + idx]);
          end
          held = cols_a[g];
          hold = 0;
          if (idx == 0) first_c = cols_a[g];
          if (idx == 1) second_c = cols_a[g];
          last_c = cols_a[g];
        end else begin
          checks++;
          if (cols_a[g] !== held) begin
            failures++;
            $display("FAIL stall_cols_stable n=%0d got %h exp %h", n, cols_a[g], held);
          end
        end
        checks++;
        if (cnt_a[g] !== 8'(idx)) begin
          failures++;
          $display("FAIL count_while_valid n=%0d got %0d exp %0d", n, cnt_a[g], idx);
        end
        if (stall_first && idx == 0 && hold < 20) ready_a[g] = 1'b0;
        if (ready_a[g]) begin
          idx++;
          in_hold  = 1'b0;
          just_acc = 1'b1;
        end else begin
          in_hold = 1'b1;
          hold++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    ready_a[g] = 1'b0;
    n_acc = idx;
    checks++;
    if (idx != exp_count[n]) begin
      failures++;
      $display("FAIL handshake_count n=%0d got %0d exp %0d", n, idx, exp_count[n]);
    end
    checks++;
    if (cnt_a[g] !== 8'(exp_count[n]) || busy_a[g] !== 1'b0 || valid_a[g] !== 1'b0) begin
      failures++;
      $display("FAIL done_state n=%0d got cnt=%0d busy=%b valid=%b exp cnt=%0d busy=0 valid=0",
               n, cnt_a[g], busy_a[g], valid_a[g], exp_count[n]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_a[g] !== 1'b1 || cnt_a[g] !== 8'(exp_count[n])) begin
      failures++;
      $display("FAIL done_hold n=%0d got done=%b cnt=%0d exp done=1 cnt=%0d", n, done_a[g], cnt_a[g], exp_count[n]);
    end
  endtask

  task automatic test_n8_backpressure;
    logic [23:0] f, s, l;
    int n_acc;
    run_full(0, 8, 100, 1'b1, f, s, l, n_acc);
    checks++;
    if (f !== pack8(0, 4, 7, 5, 2, 6, 1, 3)) begin
      failures++;
      $display("FAIL n8_first got %h exp %h", f, pack8(0, 4, 7, 5, 2, 6, 1, 3));
    end
`ifdef QUEEN_STOP_FIRST_EN
    checks++;
    if (n_acc != 1) begin
      failures++;
      $display("FAIL n8_stop_first_accepts got %0d exp 1", n_acc);
    end
`else
    checks++;
    if (s !== pack8(0, 5, 7, 2, 6, 3, 1, 4)) begin
      failures++;
      $display("FAIL n8_after_stall got %h exp %h", s, pack8(0, 5, 7, 2, 6, 3, 1, 4));
    end
    checks++;
    if (l !== pack8(7, 3, 0, 2, 5, 1, 6, 4)) begin
      failures++;
      $display("FAIL n8_last got %h exp %h", l, pack8(7, 3, 0, 2, 5, 1, 6, 4));
    end
    checks++;
    if (n_acc != 92) begin
      failures++;
      $display("FAIL n8_total got %0d exp 92", n_acc);
    end
`endif
  endtask

  // Instance 1: reset after the 10th solution, with a start pulse mid-search that must be ignored.
  task automatic test_abort;
    int idx, cyc, target;
    bit pulsed;
    target = (exp_count[8] < 10) ? exp_count[8] : 10;
    @(negedge clk);
    start_a[1] = 1'b1;
    ready_a[1] = 1'b1;
    @(negedge clk);
    start_a[1] = 1'b0;
    idx = 0; cyc = 0; pulsed = 1'b0;
    while (idx < target && cyc < 60000) begin
      start_a[1] = 1'b0;
      if (valid_a[1] === 1'b1) begin
        checks++;
        if (cols_a[1] !== model_all[model_base[8] + idx]) begin
          failures++;
          $display("FAIL abort_run_sol idx=%0d got %h exp %h", idx, cols_a[1], model_all[model_base[8] + idx]);
        end
        idx++;
      end else if (idx == 5 && !pulsed) begin
        start_a[1] = 1'b1;
        pulsed     = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start_a[1] = 1'b0;
    checks++;
    if (idx != target || cnt_a[1] !== 8'(target)) begin
      failures++;
      $display("FAIL abort_pre_reset got idx=%0d cnt=%0d exp %0d", idx, cnt_a[1], target);
    end
    rst_a[1] = 1'b1;
    @(negedge clk);
    rst_a[1] = 1'b0;
    checks++;
    if (busy_a[1] !== 1'b0 || done_a[1] !== 1'b0 || valid_a[1] !== 1'b0 || cnt_a[1] !== 8'd0) begin
      failures++;
      $display("FAIL abort_reset got busy=%b done=%b valid=%b cnt=%0d exp all zero",
               busy_a[1], done_a[1], valid_a[1], cnt_a[1]);
    end
    start_a[1] = 1'b1;
    @(negedge clk);
    start_a[1] = 1'b0;
    cyc = 0;
    while (valid_a[1] !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (valid_a[1] !== 1'b1 || cols_a[1] !== model_all[model_base[8]] || cnt_a[1] !== 8'd0) begin
      failures++;
      $display("FAIL abort_restart_first got valid=%b cols=%h cnt=%0d exp valid=1 cols=%h cnt=0",
               valid_a[1], cols_a[1], cnt_a[1], model_all[model_base[8]]);
    end
    @(negedge clk);
    checks++;
    if (cnt_a[1] !== 8'd1 || valid_a[1] !== 1'b0) begin
      failures++;
      $display("FAIL abort_restart_accept got cnt=%0d valid=%b exp cnt=1 valid=0", cnt_a[1], valid_a[1]);
    end
    ready_a[1] = 1'b0;
    rst_a[1]   = 1'b1;
    @(negedge clk);
    rst_a[1] = 1'b0;
  endtask

  task automatic test_small_boards;
    logic [23:0] f, s, l;
    int n_acc;
    run_full(2, 4, 60, 1'b0, f, s, l, n_acc);
    checks++;
    if (f !== pack8(1, 3, 0, 2, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL n4_first got %h exp %h", f, pack8(1, 3, 0, 2, 0, 0, 0, 0));
    end
`ifndef QUEEN_STOP_FIRST_EN
    checks++;
    if (l !== pack8(2, 0, 3, 1, 0, 0, 0, 0) || n_acc != 2) begin
      failures++;
      $display("FAIL n4_last got %h acc=%0d exp %h acc=2", l, n_acc, pack8(2, 0, 3, 1, 0, 0, 0, 0));
    end
`endif
    // Restart straight from DONE with a different backpressure pattern.
    run_full(2, 4, 35, 1'b0, f, s, l, n_acc);
    run_full(3, 3, 50, 1'b0, f, s, l, n_acc);
    checks++;
    if (n_acc != 0) begin
      failures++;
      $display("FAIL n3_none got %0d exp 0", n_acc);
    end
    run_full(4, 2, 50, 1'b0, f, s, l, n_acc);
    checks++;
    if (n_acc != 0) begin
      failures++;
      $display("FAIL n2_none got %0d exp 0", n_acc);
    end
    run_full(5, 1, 100, 1'b0, f, s, l, n_acc);
    checks++;
    if (n_acc != 1 || f !== 24'd0) begin
      failures++;
      $display("FAIL n1_single got acc=%0d cols=%h exp acc=1 cols=0", n_acc, f);
    end
  endtask

  initial begin
    // NOTE: bench inputs are driven with blocking assignments on the falling edge, away from the sampling edge.
    for (int g = 0; g < NI; g++) begin
      rst_a[g] = 1'b1; start_a[g] = 1'b0; ready_a[g] = 1'b0;
    end
    build_model(1);
    build_model(2);
    build_model(3);
    build_model(4);
    build_model(8);
    test_reset;
    fork
      test_n8_backpressure;
      test_abort;
    join
    test_small_boards;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
